ram2video: RTL and testbench

RAM2VIDEO -- requirements
Module: ram2video

---
 rtl/ram2video_pkg.sv | 45 ++++
 rtl/video_timing_gen.sv | 59 +++++
 rtl/ram2video.sv | 174 +++++++++++++++++
 tb/tb_ram2video.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ram2video_pkg.sv
// Shared video/line-buffer configuration for the RAM-to-video read side and the write side.
// Holds 640x480@60 timing constants, default buffer geometry, FSM state type and sync bus type.
package ram2video_pkg;

  // Default line-buffer geometry (overridable per instance)
  localparam int unsigned DEF_RAM_ADDRESS_BITS = 15;
  localparam int unsigned DEF_BUFFER_SIZE      = 32;

  // Horizontal timing (pixels)
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 752;  // exclusive

  // Vertical timing (lines)
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 492;  // exclusive

  // Counter widths
  localparam int unsigned H_BITS = 10;
  localparam int unsigned V_BITS = 10;

  // Read-side control FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Per-pixel timing flags travelling down the pipeline; syncs are active-low
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // Number of addressable pixels in a ring of buffer_size lines
  function automatic int unsigned ring_pixels(input int unsigned buffer_size);
    return buffer_size * H_ACTIVE;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// 640x480 raster counters and sync/active decode (pipeline stage 0).
// Ports:
//   clock, reset_n   : clock, async active-low reset (already release-synchronised)
//   run              : 1 = count; 0 = hold counters at (0,0) with inactive flags
//   line_start_c     : counter X is 0
//   line_end_c       : counter X is the last pixel of the line
//   frame_end_c      : last pixel of the last line of the frame
//   line_odd         : LSB of counter Y
//   sync_c           : active/hsync/vsync decode for the current counter position
module video_timing_gen
  import ram2video_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      run,
  output logic      line_start_c,
  output logic      line_end_c,
  output logic      frame_end_c,
  output logic      line_odd,
  output sync_bus_t sync_c
);

  logic [H_BITS-1:0] counter_x;
  logic [V_BITS-1:0] counter_y;

  assign line_start_c = (counter_x == '0);
  assign line_end_c   = (counter_x == H_BITS'(H_TOTAL - 1));
  assign frame_end_c  = line_end_c && (counter_y == V_BITS'(V_TOTAL - 1));
  assign line_odd     = counter_y[0];

  // Raster counters: X wraps 0..799, Y steps on X wrap and wraps 0..524
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter_x <= '0;
      counter_y <= '0;
    end else if (!run) begin
      counter_x <= '0;
      counter_y <= '0;
    end else if (line_end_c) begin
      counter_x <= '0;
      counter_y <= frame_end_c ? '0 : counter_y + V_BITS'(1);
    end else begin
      counter_x <= counter_x + H_BITS'(1);
    end
  end

  // Active area and active-low sync decode
  always_comb begin
    sync_c        = SYNC_IDLE;
    sync_c.active = run &&
                    (counter_x < H_BITS'(H_ACTIVE)) &&
                    (counter_y < V_BITS'(V_ACTIVE));
    sync_c.hsync  = !((counter_x >= H_BITS'(H_SYNC_START)) &&
                      (counter_x <  H_BITS'(H_SYNC_END)));
    sync_c.vsync  = !((counter_y >= V_BITS'(V_SYNC_START)) &&
                      (counter_y <  V_BITS'(V_SYNC_END)));
  end

endmodule

// File: rtl/ram2video.sv
// Reads 640-pixel lines from a line-buffer RAM ring and drives 640x480 RGB video.
// Optional line doubling shows every buffered line twice (240p sources).
// Ports:
//   clock, reset_n     : clock; async active-low reset (release synchronised inside)
//   starttrigger       : one-cycle pulse, writer has filled the trigger point; starts the raster
//   line_doubler       : 1 = each buffered line output twice; sampled at frame start
//   rddata             : RAM read data {R,G,B}, valid one clock after rdaddr
//   rdaddr, rdclock    : RAM read address (registered) and read clock
//   R, G, B, de        : registered pixel data and data-enable
//   hsync, vsync       : registered active-low syncs
// Pipeline: stage0 counters, stage1 rdaddr, stage2 RAM data, stage3 output registers.
module ram2video
  import ram2video_pkg::*;
#(
  parameter int unsigned RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
  parameter int unsigned BUFFER_SIZE      = DEF_BUFFER_SIZE
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        starttrigger,
  input  logic                        line_doubler,
  input  logic [23:0]                 rddata,
  output logic [RAM_ADDRESS_BITS-1:0] rdaddr,
  output logic                        rdclock,
  output logic [7:0]                  R,
  output logic [7:0]                  G,
  output logic [7:0]                  B,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de
);

  localparam int unsigned AW        = RAM_ADDRESS_BITS;
  localparam int unsigned RING_SIZE = ring_pixels(BUFFER_SIZE);

  localparam logic [AW-1:0] ADDR_LAST      = AW'(RING_SIZE - 1);
  localparam logic [AW-1:0] LINE_STEP      = AW'(H_ACTIVE);
  localparam logic [AW-1:0] LAST_LINE_BASE = AW'(RING_SIZE - H_ACTIVE);

  logic      rst_meta_n;
  logic      rst_sync_n;
  state_t    state;
  state_t    state_nxt;
  logic      run_c;

  logic      line_start_c;
  logic      line_end_c;
  logic      frame_end_c;
  logic      line_odd;
  sync_bus_t sync_c;
  sync_bus_t sync_d1;
  sync_bus_t sync_d2;

  logic [AW-1:0] line_base;
  logic [AW-1:0] base_adv_c;
  logic [AW-1:0] addr_inc_c;
  logic          frame_doubler;

  assign rdclock = clock;

  // Reset: asserts asynchronously, releases two clocks after reset_n rises
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: RUN is left only through reset, so later triggers are ignored
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (starttrigger) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign run_c = (state == ST_RUN);

  // Stage 0: raster counters and sync decode
  video_timing_gen u_timing (
    .clock        (clock),
    .reset_n      (rst_sync_n),
    .run          (run_c),
    .line_start_c (line_start_c),
    .line_end_c   (line_end_c),
    .frame_end_c  (frame_end_c),
    .line_odd     (line_odd),
    .sync_c       (sync_c)
  );

  // Ring arithmetic with explicit wrap compares (ring need not be a power of two)
  always_comb begin
    base_adv_c = line_base + LINE_STEP;
    if (line_base >= LAST_LINE_BASE) begin
      base_adv_c = line_base - LAST_LINE_BASE;
    end
    addr_inc_c = rdaddr + AW'(1);
    if (rdaddr >= ADDR_LAST) begin
      addr_inc_c = '0;
    end
  end

  // Stage 1: read address and line base. The doubler mode is latched only at
  // frame start so a mid-frame change cannot split a line pair.
  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rdaddr        <= '0;
      line_base     <= '0;
      frame_doubler <= 1'b0;
    end else if (!run_c) begin
      rdaddr        <= '0;
      line_base     <= '0;
      frame_doubler <= line_doubler;
    end else begin
      if (sync_c.active) begin
        rdaddr <= line_start_c ? line_base : addr_inc_c;
      end
      if (frame_end_c) begin
        line_base     <= '0;
        frame_doubler <= line_doubler;
      end else if (line_end_c && (!frame_doubler || line_odd)) begin
        // Doubled mode: leaving an even line keeps the base so the odd line re-reads it
        line_base <= base_adv_c;
      end
    end
  end

  // Stages 1-2: timing flags delayed to line up with RAM data
  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sync_d1 <= SYNC_IDLE;
      sync_d2 <= SYNC_IDLE;
    end else begin
      sync_d1 <= sync_c;
      sync_d2 <= sync_d1;
    end
  end

  // Stage 3: output registers, pixel data blanked outside the active area
  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      R     <= '0;
      G     <= '0;
      B     <= '0;
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      de    <= sync_d2.active;
      hsync <= sync_d2.hsync;
      vsync <= sync_d2.vsync;
      if (sync_d2.active) begin
        {R, G, B} <= rddata;
      end else begin
        {R, G, B} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram2video.sv
// Bench for ram2video with a small ring (4 lines, 12-bit address) so buffer wraps
// happen within a few lines. Per-cycle outputs are compared to a raster model
// computed from X/Y arithmetic; line start addresses are checked from a table.
module tb_ram2video;
  import ram2video_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned BS    = 4;
  localparam int          FRAME = 800 * 525;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          starttrigger;
  logic          line_doubler;
  logic [23:0]   rddata;
  logic [AW-1:0] rdaddr;
  logic          rdclock;
  logic [7:0]    R, G, B;
  logic          hsync, vsync, de;

  ram2video #(.RAM_ADDRESS_BITS(AW), .BUFFER_SIZE(BS)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .starttrigger (starttrigger),
    .line_doubler (line_doubler),
    .rddata       (rddata),
    .rdaddr       (rdaddr),
    .rdclock      (rdclock),
    .R            (R),
    .G            (G),
    .B            (B),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM with random contents
  logic [23:0] mem [0:(1<<AW)-1];
  always @(posedge clock) rddata <= mem[rdaddr];

  typedef struct packed {
    logic          rdclk;
    logic          de;
    logic          hs;
    logic          vs;
    logic [23:0]   rgb;
    logic [AW-1:0] addr;
  } obs_t;

  typedef struct {
    int ph;
    int line;
    int exp_base;
  } base_vec_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  m = 0;
  int  exp_addr = 0;
  int  phase = 0;
  bit  running = 0;
  bit  trig_pending = 0;
  bit  frame_dbl = 0;
  int  seen [0:1][0:15];

  function automatic int xpos(input int c); return c % 800; endfunction
  function automatic int ypos(input int c); return (c / 800) % 525; endfunction
  function automatic bit is_active(input int c);
    return (xpos(c) < 640) && (ypos(c) < 480);
  endfunction
  // Buffered line for output Y is Y (or Y/2 when doubled) modulo the ring size
  function automatic int pix_addr(input int c, input bit dbl);
    int line;
    line = dbl ? ypos(c) / 2 : ypos(c);
    return (line % BS) * 640 + xpos(c);
  endfunction

  task automatic check_cycle(input string tag);
    obs_t exp_o, act;
    int   c;
    act = {rdclock, de, hsync, vsync, R, G, B, rdaddr};
    exp_o = {clock, 1'b0, 1'b1, 1'b1, 24'h0, AW'(0)};
    if (running) begin
      if (m % FRAME == 0) frame_dbl = line_doubler;
      if (m >= 1 && is_active(m - 1)) begin
        exp_addr = pix_addr(m - 1, frame_dbl);
        if (xpos(m - 1) == 0 && ypos(m - 1) < 16) seen[phase][ypos(m - 1)] = int'(rdaddr);
      end
      exp_o.addr = AW'(exp_addr);
      if (m >= 3) begin
        c = m - 3;
        exp_o.de  = is_active(c);
        exp_o.hs  = !(xpos(c) >= 656 && xpos(c) < 752);
        exp_o.vs  = !(ypos(c) >= 490 && ypos(c) < 492);
        exp_o.rgb = exp_o.de ? mem[pix_addr(c, frame_dbl)] : 24'h0;
      end
    end
    n_cmp++;
    if (act !== exp_o) begin
      n_bad++;
      $display("FAIL %s m=%0d: got rdclk=%b de=%b hs=%b vs=%b rgb=%h addr=%0d, want rdclk=%b de=%b hs=%b vs=%b rgb=%h addr=%0d",
               tag, m, act.rdclk, act.de, act.hs, act.vs, act.rgb, act.addr,
               exp_o.rdclk, exp_o.de, exp_o.hs, exp_o.vs, exp_o.rgb, exp_o.addr);
    end
  endtask

  // One clock: sample at the falling edge, then drive the trigger for the next rising edge
  task automatic step(input string tag, input bit trig);
    @(negedge clock);
    if (running) m++;
    else if (trig_pending) begin
      running  = 1'b1;
      m        = 0;
      exp_addr = 0;
    end
    check_cycle(tag);
    starttrigger = trig;
    trig_pending = trig && !running && (reset_n === 1'b1);
  endtask

  base_vec_t vecs [14];

  initial begin
    int p1, p2;
    vecs[0]  = '{0, 0, 0};    vecs[1]  = '{0, 1, 640};   vecs[2]  = '{0, 2, 1280};
    vecs[3]  = '{0, 3, 1920}; vecs[4]  = '{0, 4, 0};     vecs[5]  = '{0, 5, 640};
    vecs[6]  = '{1, 0, 0};    vecs[7]  = '{1, 1, 0};     vecs[8]  = '{1, 2, 640};
    vecs[9]  = '{1, 3, 640};  vecs[10] = '{1, 6, 1920};  vecs[11] = '{1, 7, 1920};
    vecs[12] = '{1, 8, 0};    vecs[13] = '{1, 9, 0};

    for (int i = 0; i < (1 << AW); i++) mem[i] = 24'($urandom);
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 16; l++) seen[p][l] = -1;

    reset_n      = 1'b0;
    starttrigger = 1'b0;
    line_doubler = 1'b0;

    // Reset state, including a trigger pulse while reset is held
    repeat (3) step("reset", 1'b0);
    step("reset_trig", 1'b1);
    step("reset", 1'b0);
    reset_n = 1'b1;

    // Long idle without trigger
    repeat (2000) step("idle", 1'b0);

    // Phase 0: single lines, ignored extra triggers, mid-frame doubler change
    phase = 0;
    repeat ($urandom_range(1, 20)) step("pre0", 1'b0);
    step("trig0", 1'b1);
    p1 = 2 * 800 + int'($urandom_range(0, 799));
    p2 = 4 * 800 + int'($urandom_range(0, 799));
    for (int k = 0; k < 5000; k++) begin
      step("run0", running && (m == p1 || m == p2));
      if (m == 2 * 800 + 100) line_doubler = 1'b1;
      if (m == 5 * 800 + 300) break;
    end

    // Asynchronous reset mid-line: outputs return to idle without a clock edge
    #2 reset_n = 1'b0;
    running = 1'b0;
    trig_pending = 1'b0;
    #1 check_cycle("async_rst");
    repeat (4) step("rst_hold", 1'b0);
    step("rst_hold_trig", 1'b1);
    step("rst_hold", 1'b0);
    reset_n = 1'b1;
    repeat (6) step("post_rst", 1'b0);

    // Phase 1: doubled lines, doubler dropped mid-frame must not apply yet
    phase = 1;
    step("trig1", 1'b1);
    p1 = 1 * 800 + int'($urandom_range(0, 799));
    p2 = 6 * 800 + int'($urandom_range(0, 799));
    for (int k = 0; k < 9000; k++) begin
      step("run1", running && (m == p1 || m == p2));
      if (m == 3 * 800 + 50) line_doubler = 1'b0;
      if (m == 10 * 800 + 10) break;
    end

    // Line start addresses seen on rdaddr at pixel 0 of each line
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if (seen[vecs[i].ph][vecs[i].line] != vecs[i].exp_base) begin
        n_bad++;
        $display("FAIL line_base ph%0d y%0d: got %0d want %0d",
                 vecs[i].ph, vecs[i].line, seen[vecs[i].ph][vecs[i].line], vecs[i].exp_base);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
